// File: rtl/nearest_hit_resolver.sv
// Gathers one tagged intersection result per AABB lane, checks that the tags agree,
// and presents the nearest hit (smallest signed tmin) as one pixel per ray.
//
// state   | meaning
// COLLECT | accepting lane results until every holding register is full
// RESOLVE | one cycle: tag check, then register the reduction or discard the group
// OUTPUT  | resolved pixel presented, waiting for out_ready
module nearest_hit_resolver #(
   parameter int                    OBJECT_COUNT = 3,
   parameter int                    WIDTH        = 16,
   parameter int                    TAG_SIZE     = 16,
   parameter logic [WIDTH-1:0]      MAX          = 'h7FFF,
   parameter logic [23:0]           BG_COLOR     = 24'h000000,
   parameter int                    PIXEL_COUNT  = 4096
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [OBJECT_COUNT-1:0]            lane_valid,
   output logic [OBJECT_COUNT-1:0]            lane_ready,
   input  logic [OBJECT_COUNT*TAG_SIZE-1:0]   lane_tag,
   input  logic [OBJECT_COUNT-1:0]            lane_hit,
   input  logic [OBJECT_COUNT*WIDTH-1:0]      lane_tmin,
   input  logic [OBJECT_COUNT*24-1:0]         lane_color,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [TAG_SIZE-1:0]                out_tag,
   output logic                               out_hit,
   output logic [WIDTH-1:0]                   out_tmin,
   output logic [23:0]                        out_color,
   output logic [$clog2(OBJECT_COUNT):0]      out_obj,
   output logic [$clog2(PIXEL_COUNT)-1:0]     pixel_index,
   output logic                               frame_done,
   output logic                               tag_error
);

   localparam int OW = $clog2(OBJECT_COUNT) + 1;
   localparam int PW = $clog2(PIXEL_COUNT);

   typedef enum logic [1:0] {COLLECT, RESOLVE, OUTPUT} state_t;
   state_t state;

   logic [OBJECT_COUNT-1:0] full;
   logic [OBJECT_COUNT-1:0] accept;
   logic [TAG_SIZE-1:0]     hold_tag   [OBJECT_COUNT];
   logic                    hold_hit   [OBJECT_COUNT];
   logic [WIDTH-1:0]        hold_tmin  [OBJECT_COUNT];
   logic [23:0]             hold_color [OBJECT_COUNT];

   logic             red_hit;
   logic [WIDTH-1:0] red_tmin;
   logic [23:0]      red_color;
   logic [OW-1:0]    red_obj;
   logic             tag_mismatch;

   assign lane_ready = ~full & {OBJECT_COUNT{state == COLLECT}};
   assign accept     = lane_valid & lane_ready;

   // Strict less-than keeps the lowest lane index on equal tmin.
   always_comb begin
      red_hit      = 1'b0;
      red_tmin     = MAX;
      red_color    = BG_COLOR;
      red_obj      = '0;
      tag_mismatch = 1'b0;
      for (int i = 0; i < OBJECT_COUNT; i++) begin
         if (hold_hit[i] && (!red_hit || ($signed(hold_tmin[i]) < $signed(red_tmin)))) begin
            red_hit   = 1'b1;
            red_tmin  = hold_tmin[i];
            red_color = hold_color[i];
            red_obj   = OW'(i);
         end
         if (hold_tag[i] != hold_tag[0])
            tag_mismatch = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= COLLECT;
         full        <= '0;
         out_valid   <= 1'b0;
         out_hit     <= 1'b0;
         out_tmin    <= MAX;
         out_color   <= BG_COLOR;
         out_tag     <= '0;
         out_obj     <= '0;
         pixel_index <= '0;
         frame_done  <= 1'b0;
         tag_error   <= 1'b0;
         for (int i = 0; i < OBJECT_COUNT; i++) begin
            hold_tag[i]   <= '0;
            hold_hit[i]   <= 1'b0;
            hold_tmin[i]  <= '0;
            hold_color[i] <= '0;
         end
      end else begin
         frame_done <= 1'b0;
         case (state)
            COLLECT: begin
               for (int i = 0; i < OBJECT_COUNT; i++) begin
                  if (accept[i]) begin
                     full[i]       <= 1'b1;
                     hold_tag[i]   <= lane_tag[i*TAG_SIZE +: TAG_SIZE];
                     hold_hit[i]   <= lane_hit[i];
                     hold_tmin[i]  <= lane_tmin[i*WIDTH +: WIDTH];
                     hold_color[i] <= lane_color[i*24 +: 24];
                  end
               end
               // Count same-edge captures so RESOLVE follows the last accept directly.
               if (&(full | accept))
                  state <= RESOLVE;
            end
            RESOLVE: begin
               if (tag_mismatch) begin
                  tag_error <= 1'b1;
                  full      <= '0;
                  state     <= COLLECT;
               end else begin
                  out_valid <= 1'b1;
                  out_hit   <= red_hit;
                  out_tmin  <= red_tmin;
                  out_color <= red_color;
                  out_obj   <= red_obj;
                  out_tag   <= hold_tag[0];
                  state     <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  full      <= '0;
                  state     <= COLLECT;
                  if (pixel_index == PW'(PIXEL_COUNT - 1)) begin
                     pixel_index <= '0;
                     frame_done  <= 1'b1;
                  end else begin
                     pixel_index <= pixel_index + 1'b1;
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule
